s3_execute_stage: RTL

// - Execute stage directly downstream of the S2 pipeline register.
// - Consumes S2 operands, immediate, DataSrc, ALUOP and write-back controls.
// - Performs one ALU operation per cycle with EX->EX forwarding from its own output register.
// - Registers the result, destination and write enable into the S3 pipeline register for write-back.
// - Also registers status flags and a wrapping write-back counter.

---
 rtl/s3_execute_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/s3_execute_stage.sv
// Purpose : execute stage behind the S2 register. It runs one ALU operation per cycle, forwards
//           EX->EX from its own output register and registers the result, flags and write-back count.
// Latency : 1 cycle. Inputs sampled at edge N appear on S3_* after edge N.
// Backpress: none downstream. S3_Hold freezes every S3 register, the counter included.
// Ports   : clk/rst (async active-high) and S3_Hold.
//           S2_* operand/select/imm/control inputs from the S2 register.
//           S3_* registered result, destination, write enable, Zero/Carry/Overflow and S3_WbCount.
module s3_execute_stage #(
  parameter int WIDTH    = 32,
  parameter int IMM_SEXT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S3_Hold,
  input  logic [WIDTH-1:0] S2_ReadData1,
  input  logic [WIDTH-1:0] S2_ReadData2,
  input  logic [4:0]       S2_ReadSelect1,
  input  logic [4:0]       S2_ReadSelect2,
  input  logic [15:0]      S2_Imm,
  input  logic             S2_DataSrc,
  input  logic [2:0]       S2_ALUOP,
  input  logic [4:0]       S2_WriteSelect,
  input  logic             S2_WriteEnable,
  output logic [WIDTH-1:0] S3_ALUOut,
  output logic [4:0]       S3_WriteSelect,
  output logic             S3_WriteEnable,
  output logic             S3_Zero,
  output logic             S3_Carry,
  output logic             S3_Overflow,
  output logic [CNT_W-1:0] S3_WbCount
);

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_NOT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  logic [WIDTH-1:0] r_alu_out;
  logic [4:0]       r_write_sel;
  logic             r_write_en;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;
  logic [CNT_W-1:0] r_wb_count;

  logic [WIDTH-1:0] w_imm_ext;
  logic             w_fwd_a;
  logic             w_fwd_b;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;
  logic             w_we_next;

  // Immediate extension is fixed at elaboration time.
  assign w_imm_ext = (IMM_SEXT != 0) ? {{(WIDTH-16){S2_Imm[15]}}, S2_Imm}
                                     : {{(WIDTH-16){1'b0}}, S2_Imm};

  // Forward from our own output register. While held, the held values are still used.
  // Index 0 never forwards when ZERO_REG is set, because S3_WriteEnable is never 1 for it.
  assign w_fwd_a = r_write_en && (r_write_sel == S2_ReadSelect1);
  assign w_fwd_b = r_write_en && (r_write_sel == S2_ReadSelect2) && !S2_DataSrc;

  assign w_op_a = w_fwd_a ? r_alu_out : S2_ReadData1;
  assign w_op_b = S2_DataSrc ? w_imm_ext : (w_fwd_b ? r_alu_out : S2_ReadData2);

  // A shared adder handles ADD and SUB. SUB is A + ~B + 1, so the carry-out means no borrow.
  assign w_is_sub  = (S2_ALUOP == OP_SUB);
  assign w_b_eff   = w_is_sub ? ~w_op_b : w_op_b;
  assign w_sum     = {1'b0, w_op_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_add_ovf = (w_op_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != w_op_a[WIDTH-1]);
  assign w_slt     = ($signed(w_op_a) < $signed(w_op_b));

  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (S2_ALUOP)
      OP_MOV: w_result = w_op_a;
      OP_NOT: w_result = ~w_op_a;
      OP_ADD, OP_SUB: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = w_add_ovf;
      end
      OP_AND: w_result = w_op_a & w_op_b;
      OP_OR:  w_result = w_op_a | w_op_b;
      OP_XOR: w_result = w_op_a ^ w_op_b;
      OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_result = '0;
    endcase
  end

  assign w_we_next = S2_WriteEnable && !((ZERO_REG != 0) && (S2_WriteSelect == 5'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_out   <= '0;
      r_write_sel <= '0;
      r_write_en  <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_wb_count  <= '0;
    end else if (!S3_Hold) begin
      r_alu_out   <= w_result;
      r_write_sel <= S2_WriteSelect;
      r_write_en  <= w_we_next;
      r_zero      <= (w_result == '0);
      r_carry     <= w_carry;
      r_overflow  <= w_overflow;
      // The counter wraps naturally at 2^CNT_W.
      if (w_we_next) begin
        r_wb_count <= r_wb_count + CNT_W'(1);
      end
    end
  end

  assign S3_ALUOut      = r_alu_out;
  assign S3_WriteSelect = r_write_sel;
  assign S3_WriteEnable = r_write_en;
  assign S3_Zero        = r_zero;
  assign S3_Carry       = r_carry;
  assign S3_Overflow    = r_overflow;
  assign S3_WbCount     = r_wb_count;

endmodule
